// File: rtl/regfile_pkg.sv
// Shared register-file constants for the writeback path.
package regfile_pkg;

  localparam int unsigned REG_AW    = 5;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned REG_COUNT = 32;
  localparam logic [REG_AW-1:0] ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating-priority picker: first set request at or after i_ptr, wrapping at N-1.
module rr_priority_pick #(
  parameter  int unsigned N  = 3,
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  i_req,
  input  logic [PW-1:0] i_ptr,
  output logic [N-1:0]  o_grant,
  output logic [PW-1:0] o_idx,
  output logic          o_any
);

  logic [PW-1:0] w_pos;
  logic          w_found;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    w_found = 1'b0;
    w_pos   = i_ptr;
    for (int k = 0; k < int'(N); k++) begin
      if (!w_found && i_req[w_pos]) begin
        w_found        = 1'b1;
        o_idx          = w_pos;
        o_grant[w_pos] = 1'b1;
      end
      // Wrap at N-1 explicitly; N need not be a power of two.
      w_pos = (w_pos == PW'(N - 1)) ? '0 : w_pos + 1'b1;
    end
    o_any = w_found;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the regfile write port, with one registered issue stage.
module regfile_write_arbiter #(
  parameter  int unsigned NUM_REQ = 3,
  parameter  int unsigned REG_AW  = regfile_pkg::REG_AW,
  parameter  int unsigned DATA_W  = regfile_pkg::DATA_W,
  localparam int unsigned PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*REG_AW-1:0] req_reg,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      wr_hold,
  output logic                      ctrl_writeEnable,
  output logic [REG_AW-1:0]         ctrl_writeReg,
  output logic [DATA_W-1:0]         data_writeReg,
  output logic [NUM_REQ-1:0]        issue_grant,
  output logic [7:0]                drop_count
);
  import regfile_pkg::*;

  logic [PW-1:0]      r_rr_ptr;
  logic               r_we;
  logic [REG_AW-1:0]  r_wreg;
  logic [DATA_W-1:0]  r_wdata;
  logic [NUM_REQ-1:0] r_grant;
  logic [7:0]         r_drop_count;

  logic [NUM_REQ-1:0] w_req;
  logic [NUM_REQ-1:0] w_grant;
  logic [PW-1:0]      w_idx;
  logic               w_any;
  logic               w_accept;
  logic [REG_AW-1:0]  w_sel_reg;
  logic [DATA_W-1:0]  w_sel_data;
  logic [PW-1:0]      w_ptr_next;

  // Nothing is offered while in reset or stalled.
  assign w_req = (reset_n && !wr_hold) ? req_valid : '0;

  rr_priority_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .i_req   (w_req),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign req_ready = w_grant;
  assign w_accept  = w_any && |(req_valid & w_grant);

  // One-hot AND-OR mux of the winning requester's index and data.
  always_comb begin
    w_sel_reg  = '0;
    w_sel_data = '0;
    for (int i = 0; i < int'(NUM_REQ); i++) begin
      if (w_grant[i]) begin
        w_sel_reg  = w_sel_reg | req_reg[i*REG_AW +: REG_AW];
        w_sel_data = w_sel_data | req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  assign w_ptr_next = (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_rr_ptr     <= '0;
      r_we         <= 1'b0;
      r_wreg       <= '0;
      r_wdata      <= '0;
      r_grant      <= '0;
      r_drop_count <= '0;
    end else if (w_accept) begin
      r_rr_ptr <= w_ptr_next;
      if (w_sel_reg != REG_AW'(ZERO_REG)) begin
        r_we    <= 1'b1;
        r_wreg  <= w_sel_reg;
        r_wdata <= w_sel_data;
        r_grant <= w_grant;
      end else begin
        r_we         <= 1'b0;
        r_grant      <= '0;
        r_drop_count <= r_drop_count + 8'd1;
      end
    end else begin
      r_we    <= 1'b0;
      r_grant <= '0;
    end
  end

  assign ctrl_writeEnable = r_we;
  assign ctrl_writeReg    = r_wreg;
  assign data_writeReg    = r_wdata;
  assign issue_grant      = r_grant;
  assign drop_count       = r_drop_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Randomized scoreboard bench for regfile_write_arbiter with directed reset/fairness/r0/hold cases.
module tb_regfile_write_arbiter;
  localparam int N  = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic [N-1:0]    req_valid;
  logic [N*AW-1:0] req_reg;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            wr_hold;
  logic            ctrl_writeEnable;
  logic [AW-1:0]   ctrl_writeReg;
  logic [DW-1:0]   data_writeReg;
  logic [N-1:0]    issue_grant;
  logic [7:0]      drop_count;

  always #5 clock = ~clock;

  regfile_write_arbiter #(
    .NUM_REQ (N),
    .REG_AW  (AW),
    .DATA_W  (DW)
  ) dut (
    .clock            (clock),
    .reset_n          (reset_n),
    .req_valid        (req_valid),
    .req_reg          (req_reg),
    .req_data         (req_data),
    .req_ready        (req_ready),
    .wr_hold          (wr_hold),
    .ctrl_writeEnable (ctrl_writeEnable),
    .ctrl_writeReg    (ctrl_writeReg),
    .data_writeReg    (data_writeReg),
    .issue_grant      (issue_grant),
    .drop_count       (drop_count)
  );

  typedef struct {
    logic [AW-1:0] r;
    logic [DW-1:0] d;
    logic [N-1:0]  g;
  } exp_t;

  exp_t          sb[$];
  int            n_chk = 0;
  int            n_err = 0;
  logic [7:0]    exp_drop = 8'd0;
  int            rr = 0;
  int            last_win = -1;
  bit            v[N];
  logic [AW-1:0] rg[N];
  logic [DW-1:0] dt[N];
  bit            hold = 1'b0;
  int            wins[$];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]           = v[i];
      req_reg[i*AW +: AW]    = rg[i];
      req_data[i*DW +: DW]   = dt[i];
    end
    wr_hold = hold;
  endtask

  // Reference: first valid requester scanning from rr, wrapping modulo N.
  function automatic int pick();
    if (!reset_n || hold) return -1;
    for (int k = 0; k < N; k++) begin
      if (v[(rr + k) % N]) return (rr + k) % N;
    end
    return -1;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle();
    logic [N-1:0] er;
    int w;
    drive();
    #1;
    w  = pick();
    er = '0;
    if (w >= 0) er[w] = 1'b1;
    chk("req_ready", req_ready, er);
    last_win = w;
    if (w >= 0) begin
      if (rg[w] != 0) sb.push_back('{rg[w], dt[w], er});
      else exp_drop++;
      rr   = (w + 1) % N;
      v[w] = 1'b0;
    end
    @(negedge clock);
  endtask

  task automatic rst_assert();
    drive();
    reset_n = 1'b0;
    sb.delete();
    exp_drop = 8'd0;
    rr = 0;
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_we", ctrl_writeEnable, 0);
    chk("rst_wreg", ctrl_writeReg, 0);
    chk("rst_wdata", data_writeReg, 0);
    chk("rst_grant", issue_grant, 0);
    chk("rst_drop", drop_count, 0);
  endtask

  task automatic rst_release();
    repeat (2) @(negedge clock);
    drive();
    reset_n = 1'b1;
  endtask

  task automatic clear_reqs();
    for (int i = 0; i < N; i++) v[i] = 1'b0;
  endtask

  always @(posedge clock) begin : monitor
    exp_t e;
    #1;
    if (!reset_n) begin
      chk("mon_rst_we", ctrl_writeEnable, 0);
      chk("mon_rst_grant", issue_grant, 0);
    end else begin
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("issue_we", ctrl_writeEnable, 1);
        chk("issue_reg", ctrl_writeReg, e.r);
        chk("issue_data", data_writeReg, e.d);
        chk("issue_grant", issue_grant, e.g);
      end else begin
        chk("idle_we", ctrl_writeEnable, 0);
        chk("idle_grant", issue_grant, 0);
      end
      chk("drop_count", drop_count, exp_drop);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b0; rg[i] = '0; dt[i] = '0;
    end
    drive();

    // Reset with every requester valid, then release.
    for (int i = 0; i < N; i++) begin
      v[i] = 1'b1; rg[i] = AW'(i + 1); dt[i] = $urandom;
    end
    @(negedge clock);
    rst_assert();
    rst_release();
    cycle();
    chk("first_winner", last_win, 0);
    clear_reqs();
    cycle();

    // Single write.
    v[0] = 1'b1; rg[0] = 5'd7; dt[0] = 32'hDEADBEEF;
    cycle();
    cycle();
    cycle();

    // Fairness from rr_ptr = 0.
    rst_assert();
    rst_release();
    wins.delete();
    for (int c = 0; c < 6; c++) begin
      for (int i = 0; i < N; i++) begin
        v[i] = 1'b1; rg[i] = AW'($urandom_range(1, 31)); dt[i] = $urandom;
      end
      cycle();
      wins.push_back(last_win);
    end
    for (int c = 0; c < 6; c++) chk("fair_order", wins[c], c % N);
    clear_reqs();
    cycle();

    // r0 absorb and drop_count wrap.
    rst_assert();
    rst_release();
    v[1] = 1'b1; rg[1] = 5'd0; dt[1] = 32'd5;
    cycle();
    chk("r0_ready", last_win, 1);
    cycle();
    chk("drop_one", drop_count, 1);
    for (int c = 0; c < 255; c++) begin
      v[1] = 1'b1; rg[1] = 5'd0; dt[1] = $urandom;
      cycle();
    end
    cycle();
    chk("drop_wrap", drop_count, 0);

    // Hold for three cycles, then release.
    hold = 1'b1;
    v[2] = 1'b1; rg[2] = 5'd9; dt[2] = $urandom;
    repeat (3) cycle();
    hold = 1'b0;
    cycle();
    chk("hold_release_win", last_win, 2);
    cycle();

    // Asynchronous reset while the issue stage is active.
    v[0] = 1'b1; rg[0] = 5'd12; dt[0] = $urandom;
    cycle();
    chk("pre_rst_we", ctrl_writeEnable, 1);
    #2;
    rst_assert();
    rst_release();

    // Randomized traffic with duplicate indices, r0 writes and holds.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!v[i] && ($urandom % 3 == 0)) begin
          v[i]  = 1'b1;
          rg[i] = ($urandom % 4 == 0) ? '0 : AW'($urandom % 32);
          dt[i] = $urandom;
        end
      end
      hold = ($urandom % 8 == 0);
      cycle();
    end
    hold = 1'b0;
    clear_reqs();
    repeat (2) cycle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
